// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg : shared types, default widths and index-width helper for the
//                single-port SRAM arbiter.          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ       = 3;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LOCK_MAX   = 16;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if : requester bus plus SRAM port of the arbiter.
//                                                    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            lock;
  logic [NREQ-1:0]            we;
  logic [NREQ*ADDR_WIDTH-1:0] addr;
  logic [NREQ*DATA_WIDTH-1:0] wdata;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       lock_err;
  logic                       mem_en;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_din;
  logic [DATA_WIDTH-1:0]      mem_dout;

  modport master (
    output req, lock, we, addr, wdata, mem_dout,
    input  gnt, rvalid, rdata, lock_err, mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  req, lock, we, addr, wdata, mem_dout,
    output gnt, rvalid, rdata, lock_err, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

`default_nettype wire

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker : combinational round-robin pick, first request at or above ptr.
//                                                    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
  parameter int N    = 3,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    pick_o,
  output logic [IDXW-1:0] idx_o
);

  always_comb begin
    int  j;
    logic found;
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IDXW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter : round-robin arbiter with lockable ownership that drives
//                     one single-port SRAM directly.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus
);

  localparam int IDXW = clog2(NREQ);
  localparam int CNTW = clog2(LOCK_MAX);

  arb_state_t      state_q;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] owner_q;
  logic [CNTW-1:0] cnt_q;
  logic [NREQ-1:0] rvalid_q;
  logic            lock_err_q;

  logic [NREQ-1:0] w_pick;
  logic [IDXW-1:0] w_pick_idx;
  logic [NREQ-1:0] w_owner_oh;
  logic [NREQ-1:0] w_gnt;
  logic [IDXW-1:0] w_gnt_idx;
  logic            w_any_gnt;
  logic            w_gnt_lock;
  logic            w_own_req;
  logic            w_own_lock;
  logic [IDXW-1:0] ptr_d;
  logic [IDXW-1:0] w_owner_next;

  rr_picker #(.N(NREQ), .IDXW(IDXW)) u_picker (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .pick_o (w_pick),
    .idx_o  (w_pick_idx)
  );

  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < NREQ; i++) w_owner_oh[i] = (owner_q == IDXW'(i));
  end

  assign w_own_req  = |(w_owner_oh & bus.req);
  assign w_own_lock = |(w_owner_oh & bus.lock);

  // While locked only the owner may reach the SRAM; reset masks everything.
  assign w_gnt      = rst ? '0 :
                      (state_q == ARB_LOCKED) ? (w_owner_oh & bus.req) : w_pick;
  assign w_gnt_idx  = (state_q == ARB_LOCKED) ? owner_q : w_pick_idx;
  assign w_any_gnt  = |w_gnt;
  assign w_gnt_lock = |(w_gnt & bus.lock);

  assign ptr_d        = (w_gnt_idx == IDXW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_owner_next = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        bus.mem_addr = bus.mem_addr | bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_din  = bus.mem_din  | bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.gnt      = w_gnt;
  assign bus.mem_en   = w_any_gnt;
  assign bus.mem_we   = |(w_gnt & bus.we);
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = bus.mem_dout;
  assign bus.lock_err = lock_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      rvalid_q   <= '0;
      lock_err_q <= 1'b0;
    end else begin
      rvalid_q   <= w_gnt & ~bus.we;
      lock_err_q <= 1'b0;
      if (w_any_gnt) ptr_q <= ptr_d;
      case (state_q)
        ARB_IDLE: begin
          if (w_any_gnt && w_gnt_lock) begin
            state_q <= ARB_LOCKED;
            owner_q <= w_pick_idx;
            cnt_q   <= '0;
          end
        end
        ARB_LOCKED: begin
          cnt_q <= cnt_q + 1'b1;
          // Timeout wins over a voluntary release; the owner's access still completes.
          if (cnt_q == CNTW'(LOCK_MAX - 1)) begin
            state_q    <= ARB_IDLE;
            lock_err_q <= 1'b1;
            ptr_q      <= w_owner_next;
          end else if ((w_any_gnt && !w_own_lock) || (!w_own_req && !w_own_lock)) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port SRAM (the vocab, input and output memories of the grouper datapath) between up to NREQ requesters, e.g. host loader, matcher read port and grouper write-back. Each cycle it grants at most one request, round-robin. A requester can lock the port for atomic read-modify-write sequences such as reading a token pair and overwriting it with the merged token. The arbiter drives the SRAM port directly and returns read data with an owner-tagged valid pulse.

## Interface
- NREQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 4, SRAM address width
- DATA_WIDTH, 8, SRAM word width
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester access request, held until granted
- lock  in  NREQ  per-requester: keep ownership after this access
- we  in  NREQ  per-requester write enable (1 = write)
- addr  in  NREQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  NREQ*DATA_WIDTH  packed write data, same packing
- gnt  out  NREQ  one-hot grant; the access completes at this clock edge
- rvalid  out  NREQ  one-hot, one cycle after a read grant to that requester
- rdata  out  DATA_WIDTH  read data, valid while any rvalid bit is 1
- lock_err  out  1  one-cycle pulse on forced lock release
- mem_en, mem_we  out  1  SRAM port enable and write enable
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_din  out  DATA_WIDTH  SRAM write data
- mem_dout  in  DATA_WIDTH  SRAM read data, one-cycle latency

## Operation
- States: IDLE (no owner) and LOCKED (owner register valid, lock counter running).
- IDLE grant rule: scan req from index ptr upward, modulo NREQ. The first asserted index wins.
- LOCKED grant rule: only the owner can be granted. All other requests wait, with gnt=0.
- gnt is combinational from req, state and ptr. mem_en equals OR(gnt). mem_we, mem_addr and mem_din are muxed from the granted requester. When nothing is granted they are 0.
- On each grant to index g:
  - ptr becomes (g+1) mod NREQ.
  - For a read, rvalid[g] is registered as 1 for the next cycle, and rdata is mem_dout.
- Lock entry: grant to g with lock[g]=1 in IDLE → LOCKED, owner=g, cnt=0.
- Lock release, LOCKED → IDLE at the edge where either condition holds:
  - the owner is granted with lock[g]=0 (that access still completes), or
  - the owner has req=0 and lock=0.
- Forced release: cnt increments every LOCKED cycle. At cnt=LOCK_MAX-1 the state goes to IDLE at the next edge and lock_err pulses for one cycle. A grant in that cycle still completes. ptr becomes owner+1.
- A write followed by a read of the same address from any requester returns the new data, because the SRAM is write-first across cycles.
- A requester that drops req before being granted gets no access and no rvalid.

## Timing
- Reset values: state=IDLE, ptr=0, owner=0, cnt=0, rvalid=0, lock_err=0. gnt and mem_* are 0 while rst=1.
- Grant latency is 0 cycles, since gnt is in the same cycle as req when the requester wins. Read data latency is 1 cycle after the grant.
- Fairness: with all NREQ requesting continuously and no lock, each requester is granted exactly once per NREQ cycles.
- Worst-case wait: (NREQ-1)·LOCK_MAX + NREQ - 1 cycles.
- Reset mid-operation: asserting rst clears the lock and any pending rvalid immediately. No partial access is reissued after reset.
- Back-to-back grants to the same requester are allowed only when it is the sole requester or the owner.

## Structure
- Package sram_arb_pkg holds:
  - the state enum arb_state_t {ARB_IDLE, ARB_LOCKED}
  - the default width constants
  - an index-width function clog2 for NREQ
- Sub-module rr_picker (combinational): inputs are req and ptr, outputs are a one-hot pick and its index. It is reused wherever round-robin selection is needed.
- The top level contains the state, lock counter, ptr/owner registers and the datapath muxes.

## Test plan
- Single read: after reset, req[1]=1 with addr=4'h3 and the memory word 8'hA5 → gnt=3'b010 in the same cycle; next cycle rvalid=3'b010 and rdata=8'hA5.
- Contention: all three requesters assert req from reset → grants 0,1,2,0,1,2 on consecutive cycles; ptr=0 again after each third grant.
- Locked RMW: req[1] reads addr 5 with lock=1, then writes 8'h42 with lock=0, while req[0] and req[2] are held → 0 and 2 see no gnt for both cycles; then 2 is granted, then 0. A read of addr 5 returns 8'h42.
- Lock timeout with LOCK_MAX=4: requester 0 holds lock=1 and req=0 → lock_err pulses once after 4 locked cycles; requester 1 is granted the following cycle.
- Reset mid-lock: rst=1 while LOCKED with a read grant pending → rvalid=0 in the next cycle; after rst falls, state=IDLE, ptr=0, and requester 0 is granted first.
- Write/read ordering: requester 2 writes 8'hFF to addr 0, and requester 0 reads addr 0 in the next cycle → rdata=8'hFF.
